// File: rtl/dijeljenje_seq_if.sv
// Handshake and operand/result bundle for the sequential sign-magnitude divider.
interface dijeljenje_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, div_by_zero, overflow
    );
endinterface

// File: rtl/dijeljenje_seq.sv
// Restoring sign-magnitude fixed-point divider, one quotient bit per clock.
// Result is formed in the DONE state and registered together with the done pulse.
module dijeljenje_seq #(
    parameter int W    = 16,
    parameter int FRAC = 10
) (
    input  logic             clk,
    input  logic             rst,
    dijeljenje_seq_if.slave  bus
);
    localparam int N  = W - 1 + FRAC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   num_q, num_d;
    logic [W-2:0]   dvs_q, dvs_d;
    logic [W-2:0]   rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sign_q, sign_d;
    logic           dz_q, dz_d;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dzo_q, dzo_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   quot_q, quot_d;

    logic [W-1:0]   rem_shift_s;
    logic [W-2:0]   mag_s;
    logic           ovf_s;

    // Next-state, datapath iteration and result formation
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        dz_d        = dz_q;
        done_d      = 1'b0;
        dzo_d       = dzo_q;
        ovf_d       = ovf_q;
        quot_d      = quot_q;
        rem_shift_s = {rem_q, num_q[N-1]};
        mag_s       = '0;
        ovf_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sign_d = bus.dividend[W-1] ^ bus.divisor[W-1];
                    num_d  = {bus.dividend[W-2:0], {FRAC{1'b0}}};
                    dvs_d  = bus.divisor[W-2:0];
                    rem_d  = '0;
                    quo_d  = '0;
                    cnt_d  = '0;
                    if (bus.divisor[W-2:0] == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                num_d = {num_q[N-2:0], 1'b0};
                // Remainder never exceeds the divisor, so W-1 bits hold it after the subtract
                if (rem_shift_s >= {1'b0, dvs_q}) begin
                    rem_d = rem_shift_s[W-2:0] - dvs_q;
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift_s[W-2:0];
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end

            S_DONE: begin
                if (dz_q) begin
                    mag_s = '1;
                    ovf_s = 1'b0;
                end else if (|quo_q[N-1:W-1]) begin
                    mag_s = '1;
                    ovf_s = 1'b1;
                end else begin
                    mag_s = quo_q[W-2:0];
                    ovf_s = 1'b0;
                end
                quot_d  = {sign_q & (mag_s != '0), mag_s};
                dzo_d   = dz_q;
                ovf_d   = ovf_s;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.div_by_zero = dzo_q;
    assign bus.overflow    = ovf_q;
endmodule
